// File: rtl/peripheral_msi_ahb3_pkg.sv
// Shared AHB3-Lite encodings, arbiter FSM states and burst helpers for the
// MSI slave-port arbiter.
package peripheral_msi_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        INCR   = 2'd2,
        LOCKED = 2'd3
    } arb_state_t;

    // Number of beats in a fixed-length burst, minus one (0 for SINGLE/INCR).
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   return 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

    // True for the six fixed-length burst encodings.
    function automatic logic is_fixed_burst(input logic [2:0] hburst);
        return (hburst != HBURST_SINGLE) && (hburst != HBURST_INCR);
    endfunction

endpackage

// File: rtl/peripheral_msi_rr_select_ahb3.sv
// Combinational master selector: highest priority level among requesters,
// round-robin within that level starting after the level's last winner.
module peripheral_msi_rr_select_ahb3
    import peripheral_msi_ahb3_pkg::*;
#(
    parameter int MASTERS   = 5,
    parameter int PRIO_BITS = 3,
    localparam int IDX_W    = $clog2(MASTERS),
    localparam int LEVELS   = 1 << PRIO_BITS
) (
    input  logic [MASTERS-1:0]                req,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] prio,
    input  logic [LEVELS-1:0][IDX_W-1:0]      last_granted,
    input  logic [MASTERS-1:0]                cur_grant,
    output logic [MASTERS-1:0]                next_grant,
    output logic [IDX_W-1:0]                  next_idx,
    output logic [PRIO_BITS-1:0]              level,
    output logic                              found
);

    logic [IDX_W-1:0] cand;
    logic             hit;

    // Find the highest priority level among the requesting masters.
    always_comb begin
        level = '0;
        found = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (req[i] && (!found || prio[i] > level)) begin
                level = prio[i];
                found = 1'b1;
            end
        end
    end

    // Rotate from the master after the level's last winner; keep grant if idle.
    always_comb begin
        cand     = '0;
        hit      = 1'b0;
        next_idx = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            cand = IDX_W'((int'(last_granted[level]) + k) % MASTERS);
            if (!hit && req[cand] && prio[cand] == level) begin
                hit      = 1'b1;
                next_idx = cand;
            end
        end
        next_grant = found ? (MASTERS'(1) << next_idx) : cur_grant;
    end

endmodule

// File: rtl/peripheral_msi_slave_port_arb_ahb3.sv
// AHB3-Lite slave-port arbiter: muxes several master request buses onto one
// slave, with burst- and lock-aware switching and an INCR starvation limit.
module peripheral_msi_slave_port_arb_ahb3
    import peripheral_msi_ahb3_pkg::*;
#(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int MASTERS    = 5,
    parameter int PRIO_BITS  = 3,
    parameter int STARVE_MAX = 16
) (
    input  logic                              HCLK,
    input  logic                              HRESET,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] mstpriority,
    input  logic [MASTERS-1:0]                mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]      mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]      mstHWDATA,
    input  logic [MASTERS-1:0]                mstHWRITE,
    input  logic [MASTERS-1:0][2:0]           mstHSIZE,
    input  logic [MASTERS-1:0][2:0]           mstHBURST,
    input  logic [MASTERS-1:0][3:0]           mstHPROT,
    input  logic [MASTERS-1:0][1:0]           mstHTRANS,
    input  logic [MASTERS-1:0]                mstHMASTLOCK,
    input  logic [MASTERS-1:0]                mstHREADY,
    output logic [XLEN-1:0]                   mstHRDATA,
    output logic                              mstHREADYOUT,
    output logic                              mstHRESP,
    output logic                              slv_HSEL,
    output logic [PLEN-1:0]                   slv_HADDR,
    output logic [XLEN-1:0]                   slv_HWDATA,
    output logic                              slv_HWRITE,
    output logic [2:0]                        slv_HSIZE,
    output logic [2:0]                        slv_HBURST,
    output logic [3:0]                        slv_HPROT,
    output logic [1:0]                        slv_HTRANS,
    output logic                              slv_HMASTLOCK,
    output logic                              slv_HREADYOUT,
    input  logic [XLEN-1:0]                   slv_HRDATA,
    input  logic                              slv_HREADY,
    input  logic                              slv_HRESP,
    output logic [MASTERS-1:0]                granted_master,
    output logic [1:0]                        arb_state
);

    localparam int IDX_W      = $clog2(MASTERS);
    localparam int LEVELS     = 1 << PRIO_BITS;
    localparam int STV_W      = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int STARVE_LIM = (STARVE_MAX > 0) ? STARVE_MAX - 1 : 0;
    localparam logic [STV_W-1:0] STARVE_LIM_V = STV_W'(STARVE_LIM);

    // Saturating increment for the starvation counter.
    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [MASTERS-1:0]             grant;
    logic [IDX_W-1:0]               addr_idx;
    logic [IDX_W-1:0]               data_idx;
    logic [LEVELS-1:0][IDX_W-1:0]   last_granted;
    logic [3:0]                     beat_cnt, beat_nxt;
    logic [STV_W-1:0]               starve_cnt, starve_nxt, starve_inc;
    arb_state_t                     state, state_nxt;
    logic                           first_phase;

    logic                           owner_sel;
    logic                           owner_lock;
    logic [1:0]                     owner_trans;
    logic [1:0]                     eff_trans;
    logic [2:0]                     owner_burst;
    logic                           competitor;
    logic                           rearb;
    logic                           excl_owner;
    logic                           do_decode;

    logic [MASTERS-1:0]             req;
    logic [MASTERS-1:0]             sel_grant;
    logic [IDX_W-1:0]               sel_idx;
    logic [PRIO_BITS-1:0]           sel_level;
    logic                           sel_found;

    // A forced starvation switch must hand the bus to someone else.
    assign req = excl_owner ? (mstHSEL & ~grant) : mstHSEL;

    peripheral_msi_rr_select_ahb3 #(
        .MASTERS   (MASTERS),
        .PRIO_BITS (PRIO_BITS)
    ) u_select (
        .req          (req),
        .prio         (mstpriority),
        .last_granted (last_granted),
        .cur_grant    (grant),
        .next_grant   (sel_grant),
        .next_idx     (sel_idx),
        .level        (sel_level),
        .found        (sel_found)
    );

    // Owner view, with SEQ/BUSY fix-up on the first address phase after a switch.
    always_comb begin
        owner_sel   = mstHSEL[addr_idx];
        owner_lock  = mstHMASTLOCK[addr_idx];
        owner_trans = mstHTRANS[addr_idx];
        owner_burst = mstHBURST[addr_idx];
        eff_trans   = owner_trans;
        if (first_phase) begin
            if (owner_trans == HTRANS_SEQ)  eff_trans = HTRANS_NONSEQ;
            if (owner_trans == HTRANS_BUSY) eff_trans = HTRANS_IDLE;
        end
        competitor = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (IDX_W'(i) != addr_idx && mstHSEL[i] &&
                mstpriority[i] >= mstpriority[addr_idx]) begin
                competitor = 1'b1;
            end
        end
    end

    // Next-state and switch decision from the owner's current address phase.
    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        starve_nxt = starve_cnt;
        starve_inc = sat_inc(starve_cnt);
        rearb      = 1'b0;
        excl_owner = 1'b0;
        do_decode  = 1'b0;
        case (state)
            IDLE: do_decode = 1'b1;
            BURST: begin
                if (slv_HRESP) begin
                    state_nxt = IDLE;
                    beat_nxt  = 4'd0;
                end else if (!owner_sel || eff_trans == HTRANS_IDLE ||
                             eff_trans == HTRANS_NONSEQ) begin
                    do_decode = 1'b1;
                end else if (eff_trans == HTRANS_SEQ) begin
                    if (beat_cnt <= 4'd1) begin
                        beat_nxt  = 4'd0;
                        state_nxt = IDLE;
                        rearb     = 1'b1;
                    end else begin
                        beat_nxt = beat_cnt - 4'd1;
                    end
                end
            end
            INCR: begin
                if (slv_HRESP) begin
                    state_nxt  = IDLE;
                    starve_nxt = '0;
                end else if (!owner_sel || eff_trans == HTRANS_IDLE ||
                             eff_trans == HTRANS_NONSEQ) begin
                    do_decode = 1'b1;
                end else if (eff_trans == HTRANS_SEQ) begin
                    // starve_inc counts the SEQ beats accepted including this one.
                    if (STARVE_MAX != 0 && starve_inc >= STARVE_LIM_V && competitor) begin
                        state_nxt  = IDLE;
                        starve_nxt = '0;
                        rearb      = 1'b1;
                        excl_owner = 1'b1;
                    end else begin
                        starve_nxt = starve_inc;
                    end
                end
            end
            LOCKED: begin
                if (!owner_lock && (eff_trans == HTRANS_IDLE ||
                                    eff_trans == HTRANS_NONSEQ)) begin
                    do_decode = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_decode) begin
            state_nxt  = IDLE;
            beat_nxt   = 4'd0;
            starve_nxt = '0;
            if (owner_sel && eff_trans == HTRANS_NONSEQ) begin
                if (owner_lock) begin
                    state_nxt = LOCKED;
                end else if (is_fixed_burst(owner_burst)) begin
                    state_nxt = BURST;
                    beat_nxt  = burst_beats_m1(owner_burst);
                end else if (owner_burst == HBURST_INCR) begin
                    state_nxt = INCR;
                end else begin
                    rearb = 1'b1;
                end
            end else begin
                rearb = 1'b1;
            end
        end
    end

    // Arbiter state register; everything advances only on slave-ready cycles.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant        <= MASTERS'(1);
            addr_idx     <= '0;
            data_idx     <= '0;
            last_granted <= '0;
            beat_cnt     <= 4'd0;
            starve_cnt   <= '0;
            state        <= IDLE;
            first_phase  <= 1'b0;
        end else if (slv_HREADY) begin
            state       <= state_nxt;
            beat_cnt    <= beat_nxt;
            starve_cnt  <= starve_nxt;
            data_idx    <= addr_idx;
            first_phase <= 1'b0;
            if (rearb && sel_found) begin
                grant                   <= sel_grant;
                addr_idx                <= sel_idx;
                last_granted[sel_level] <= sel_idx;
                first_phase             <= (sel_idx != addr_idx);
            end
        end
    end

    assign slv_HSEL       = mstHSEL[addr_idx];
    assign slv_HADDR      = mstHADDR[addr_idx];
    assign slv_HWDATA     = mstHWDATA[data_idx];
    assign slv_HWRITE     = mstHWRITE[addr_idx];
    assign slv_HSIZE      = mstHSIZE[addr_idx];
    assign slv_HBURST     = mstHBURST[addr_idx];
    assign slv_HPROT      = mstHPROT[addr_idx];
    assign slv_HTRANS     = eff_trans;
    assign slv_HMASTLOCK  = mstHMASTLOCK[addr_idx];
    assign slv_HREADYOUT  = mstHREADY[addr_idx];
    assign mstHRDATA      = slv_HRDATA;
    assign mstHREADYOUT   = slv_HREADY;
    assign mstHRESP       = slv_HRESP;
    assign granted_master = grant;
    assign arb_state      = state;

endmodule

// File: tb/tb_peripheral_msi_slave_port_arb_ahb3.sv
// Directed bench for the AHB3 slave-port arbiter.
module tb_peripheral_msi_slave_port_arb_ahb3;

    localparam int M = 5;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                           B_INCR8 = 3'd5, B_WRAP16 = 3'd6;
    localparam logic [1:0] S_IDLE = 2'd0, S_BURST = 2'd1, S_INCR = 2'd2, S_LOCKED = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic [M-1:0][2:0] prio;
    logic [M-1:0]      hsel, hwrite, hlock, hready_m;
    logic [M-1:0][63:0] haddr, hwdata;
    logic [M-1:0][2:0] hsize, hburst;
    logic [M-1:0][3:0] hprot;
    logic [M-1:0][1:0] htrans;
    logic [63:0]       m_hrdata;
    logic              m_hreadyout, m_hresp;
    logic              s_hsel, s_hwrite, s_hmastlock, s_hreadyout;
    logic [63:0]       s_haddr, s_hwdata;
    logic [2:0]        s_hsize, s_hburst;
    logic [3:0]        s_hprot;
    logic [1:0]        s_htrans;
    logic [63:0]       s_hrdata;
    logic              s_hready, s_hresp;
    logic [M-1:0]      granted;
    logic [1:0]        st;

    int checks = 0;
    int errors = 0;

    peripheral_msi_slave_port_arb_ahb3 #(
        .PLEN(64), .XLEN(64), .MASTERS(M), .PRIO_BITS(3), .STARVE_MAX(4)
    ) dut (
        .HCLK(clk), .HRESET(rst), .mstpriority(prio),
        .mstHSEL(hsel), .mstHADDR(haddr), .mstHWDATA(hwdata), .mstHWRITE(hwrite),
        .mstHSIZE(hsize), .mstHBURST(hburst), .mstHPROT(hprot), .mstHTRANS(htrans),
        .mstHMASTLOCK(hlock), .mstHREADY(hready_m),
        .mstHRDATA(m_hrdata), .mstHREADYOUT(m_hreadyout), .mstHRESP(m_hresp),
        .slv_HSEL(s_hsel), .slv_HADDR(s_haddr), .slv_HWDATA(s_hwdata),
        .slv_HWRITE(s_hwrite), .slv_HSIZE(s_hsize), .slv_HBURST(s_hburst),
        .slv_HPROT(s_hprot), .slv_HTRANS(s_htrans), .slv_HMASTLOCK(s_hmastlock),
        .slv_HREADYOUT(s_hreadyout), .slv_HRDATA(s_hrdata), .slv_HREADY(s_hready),
        .slv_HRESP(s_hresp), .granted_master(granted), .arb_state(st)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lk, input logic [2:0] pr);
        hsel[m]   = sel;
        htrans[m] = tr;
        hburst[m] = bu;
        hlock[m]  = lk;
        prio[m]   = pr;
    endtask

    initial begin
        rst = 1'b1;
        s_hready = 1'b1;
        s_hresp = 1'b0;
        s_hrdata = '0;
        for (int i = 0; i < M; i++) begin
            drive(i, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd0);
            haddr[i]    = 64'(i + 1) << 12;
            hwdata[i]   = 64'hD0D0_0000 + 64'(i);
            hwrite[i]   = 1'(i);
            hsize[i]    = 3'd2;
            hprot[i]    = 4'd3;
            hready_m[i] = 1'b1;
        end
        step();
        step();
        check("rst_grant", granted, 5'b00001);
        check("rst_state", st, S_IDLE);
        check("rst_haddr", s_haddr, 64'h1000);
        check("rst_hsel", s_hsel, 1'b0);
        rst = 1'b0;

        // Single transfer from master 2
        drive(2, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd1);
        step();
        check("t1_grant", granted, 5'b00100);
        check("t1_haddr", s_haddr, 64'h3000);
        check("t1_htrans", s_htrans, T_NS);
        check("t1_state", st, S_IDLE);
        step();
        check("t1_hwdata", s_hwdata, 64'hD0D0_0002);
        hready_m[2] = 1'b0;
        #1;
        check("t1_hreadyout", s_hreadyout, 1'b0);
        hready_m[2] = 1'b1;
        s_hrdata = 64'hCAFE_F00D;
        #1;
        check("t1_hrdata", m_hrdata, 64'hCAFE_F00D);
        drive(2, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd1);

        // Equal-priority round robin, then a higher-priority master
        drive(1, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd2);
        drive(3, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd2);
        step(); check("t2_rr0", granted, 5'b00010);
        step(); check("t2_rr1", granted, 5'b01000);
        step(); check("t2_rr2", granted, 5'b00010);
        step(); check("t2_rr3", granted, 5'b01000);
        drive(4, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd5);
        step(); check("t2_high", granted, 5'b10000);
        drive(1, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd2);
        drive(3, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd2);
        drive(4, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd5);
        step(); check("t2_keep", granted, 5'b10000);

        // INCR8 from master 0 must not be interrupted by master 4
        drive(0, 1'b1, T_NS, B_INCR8, 1'b0, 3'd0);
        step(); check("t3_grant", granted, 5'b00001);
        step(); check("t3_burst", st, S_BURST);
        htrans[0] = T_SEQ;
        for (int b = 2; b <= 7; b++) begin
            if (b == 3) drive(4, 1'b1, T_SEQ, B_INCR, 1'b0, 3'd6);
            if (b == 4) begin
                s_hready = 1'b0;
                step();
                check("t3_wait_grant", granted, 5'b00001);
                s_hready = 1'b1;
            end
            if (b == 5) begin
                htrans[0] = T_BUSY;
                step();
                check("t3_busy_state", st, S_BURST);
                htrans[0] = T_SEQ;
            end
            step();
            check("t3_hold_grant", granted, 5'b00001);
            check("t3_hold_state", st, S_BURST);
        end
        step();
        check("t3_switch_grant", granted, 5'b10000);
        check("t3_switch_state", st, S_IDLE);
        check("t3_seq_fix", s_htrans, T_NS);
        check("t3_dphase_wdata", s_hwdata, 64'hD0D0_0000);
        drive(0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd0);
        step(); check("t3_m4_incr", st, S_INCR);
        drive(4, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd6);
        step();
        check("t3_end_state", st, S_IDLE);
        check("t3_end_grant", granted, 5'b10000);

        // Locked sequence from master 1 while master 2 waits at top priority
        drive(1, 1'b1, T_NS, B_INCR, 1'b1, 3'd1);
        step(); check("t4_grant", granted, 5'b00010);
        step(); check("t4_locked", st, S_LOCKED);
        drive(2, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd7);
        for (int i = 1; i <= 19; i++) begin
            htrans[1] = (i == 10) ? T_IDLE : T_SEQ;
            step();
            check("t4_lock_state", st, S_LOCKED);
            check("t4_lock_grant", granted, 5'b00010);
        end
        hlock[1]  = 1'b0;
        htrans[1] = T_IDLE;
        step();
        check("t4_release_grant", granted, 5'b00100);
        check("t4_release_state", st, S_IDLE);
        drive(1, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd1);
        drive(2, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd7);
        step();

        // Starvation limit of 4 beats on an undefined-length INCR
        drive(0, 1'b1, T_NS, B_INCR, 1'b0, 3'd3);
        step(); check("t5_grant", granted, 5'b00001);
        step(); check("t5_incr", st, S_INCR);
        htrans[0] = T_SEQ;
        drive(1, 1'b1, T_BUSY, B_INCR, 1'b0, 3'd3);
        step(); check("t5_beat2", granted, 5'b00001);
        step(); check("t5_beat3", granted, 5'b00001);
        step();
        check("t5_forced_grant", granted, 5'b00010);
        check("t5_forced_state", st, S_IDLE);
        check("t5_dphase_wdata", s_hwdata, 64'hD0D0_0000);
        check("t5_busy_fix", s_htrans, T_IDLE);
        step();
        check("t5_back_grant", granted, 5'b00001);
        check("t5_back_seq_fix", s_htrans, T_NS);
        drive(0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd3);
        drive(1, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd3);
        step();

        // Error response aborts burst tracking
        drive(3, 1'b1, T_NS, B_INCR4, 1'b0, 3'd2);
        step(); check("t6_grant", granted, 5'b01000);
        step(); check("t6_burst", st, S_BURST);
        htrans[3] = T_SEQ;
        s_hresp = 1'b1;
        #1;
        check("t6_hresp", m_hresp, 1'b1);
        step(); check("t6_abort", st, S_IDLE);
        s_hresp = 1'b0;

        // Wait states then reset in the middle of a WRAP16
        htrans[3] = T_NS;
        hburst[3] = B_WRAP16;
        step(); check("t7_burst", st, S_BURST);
        htrans[3] = T_SEQ;
        step(); step(); step();
        check("t7_mid_grant", granted, 5'b01000);
        s_hready = 1'b0;
        drive(1, 1'b1, T_NS, B_SINGLE, 1'b0, 3'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t7_wait_grant", granted, 5'b01000);
            check("t7_wait_state", st, S_BURST);
        end
        rst = 1'b1;
        step();
        check("t7_rst_grant", granted, 5'b00001);
        check("t7_rst_state", st, S_IDLE);
        check("t7_rst_haddr", s_haddr, 64'h1000);
        rst = 1'b0;
        s_hready = 1'b1;
        for (int i = 0; i < M; i++) drive(i, 1'b0, T_IDLE, B_SINGLE, 1'b0, 3'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
